// File: rtl/beam_coeff_scheduler.sv
// beam_coeff_scheduler: ping/pong coefficient bank sequencer feeding the beamformer core.
// Optional feature macro: SAMPLE_DROP_CNT_EN adds drop_count_o (rejected sample-set counter).
module beam_coeff_scheduler #(
   parameter  int MAX_BEAMS       = 8,
   parameter  int NUM_CH_PER_LANE = 4,
   parameter  int COEFF_WIDTH     = 16,
   parameter  int BEAM_W          = 3,
   localparam int W               = NUM_CH_PER_LANE * 2 * COEFF_WIDTH
) (
   input  logic              core_clk,
   input  logic              core_rst,
   input  logic              sample_valid_i,
   output logic              sample_ready_o,
   output logic [W-1:0]      coeff_data_o,
   output logic              coeff_valid_o,
   input  logic              coeff_ready_i,
   output logic [BEAM_W-1:0] coeff_beam_o,
   output logic              coeff_last_o,
   input  logic              cfg_wr_en_i,
   input  logic [BEAM_W-1:0] cfg_wr_addr_i,
   input  logic [W-1:0]      cfg_wr_data_i,
   input  logic [BEAM_W:0]   cfg_num_beams_i,
   input  logic              cfg_commit_i,
   output logic              cfg_busy_o,
   output logic              active_bank_o,
   output logic [15:0]       frame_count_o
`ifdef SAMPLE_DROP_CNT_EN
   ,
   output logic [15:0]       drop_count_o
`endif
);

   localparam int NB_W = BEAM_W + 1;
   localparam int AW   = (MAX_BEAMS > 1) ? $clog2(MAX_BEAMS) : 1;

   localparam logic [NB_W-1:0] NB_ONE = NB_W'(1);
   localparam logic [NB_W-1:0] NB_MAX = NB_W'(MAX_BEAMS);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SWAP  = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [BEAM_W-1:0] beam_q, beam_d;
   logic              active_q, active_d;
   logic [NB_W-1:0]   nact_q, nact_d;
   logic [NB_W-1:0]   nshd_q, nshd_d;
   logic              busy_q, busy_d;
   logic [15:0]       frame_q, frame_d;

   logic [W-1:0]      bank_q [2][MAX_BEAMS];

   logic              issue;
   logic              is_last;
   logic              wr_ok;
   logic              cm_ok;
   logic [NB_W-1:0]   nb_clamp;

   assign issue   = (state_q == S_ISSUE);
   assign is_last = ({1'b0, beam_q} == (nact_q - NB_ONE));

   // The shadow bank is frozen between commit and swap.
   assign wr_ok = cfg_wr_en_i && !busy_q
                  && ({1'b0, cfg_wr_addr_i} < NB_MAX);
   assign cm_ok = cfg_commit_i && !busy_q;

   // Clamp the requested beam count into 1..MAX_BEAMS.
   always_comb begin
      nb_clamp = cfg_num_beams_i;
      if (cfg_num_beams_i == '0) begin
         nb_clamp = NB_ONE;
      end else if (cfg_num_beams_i > NB_MAX) begin
         nb_clamp = NB_MAX;
      end
   end

   // Sequencer next state: accept a set, walk its beams, swap banks between sets.
   always_comb begin
      state_d  = state_q;
      beam_d   = beam_q;
      active_d = active_q;
      nact_d   = nact_q;
      nshd_d   = nshd_q;
      busy_d   = busy_q;
      frame_d  = frame_q;
      unique case (state_q)
         S_IDLE: begin
            if (busy_q) begin
               state_d = S_SWAP;
            end else if (sample_valid_i) begin
               state_d = S_ISSUE;
               beam_d  = '0;
            end
         end
         S_SWAP: begin
            active_d = ~active_q;
            nact_d   = nshd_q;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
         S_ISSUE: begin
            if (coeff_ready_i) begin
               if (is_last) begin
                  state_d = S_IDLE;
                  beam_d  = '0;
                  frame_d = frame_q + 16'd1;
               end else begin
                  beam_d = beam_q + BEAM_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (cm_ok) begin
         busy_d = 1'b1;
         nshd_d = nb_clamp;
      end
   end

   // Control registers; reset aborts any set in flight without counting it.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q  <= S_IDLE;
         beam_q   <= '0;
         active_q <= 1'b0;
         nact_q   <= NB_ONE;
         nshd_q   <= NB_ONE;
         busy_q   <= 1'b0;
         frame_q  <= '0;
      end else begin
         state_q  <= state_d;
         beam_q   <= beam_d;
         active_q <= active_d;
         nact_q   <= nact_d;
         nshd_q   <= nshd_d;
         busy_q   <= busy_d;
         frame_q  <= frame_d;
      end
   end

   // Coefficient banks; only the shadow (inactive) bank takes host writes.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < MAX_BEAMS; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else if (wr_ok) begin
         bank_q[~active_q][cfg_wr_addr_i[AW-1:0]] <= cfg_wr_data_i;
      end
   end

   assign sample_ready_o = (state_q == S_IDLE) && !busy_q && !core_rst;
   assign coeff_valid_o  = issue;
   assign coeff_data_o   = bank_q[active_q][beam_q[AW-1:0]];
   assign coeff_beam_o   = beam_q;
   assign coeff_last_o   = issue && is_last;
   assign cfg_busy_o     = busy_q;
   assign active_bank_o  = active_q;
   assign frame_count_o  = frame_q;

`ifdef SAMPLE_DROP_CNT_EN
   logic [15:0] drop_q;

   // Count offered sample sets the scheduler could not take, saturating.
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         drop_q <= '0;
      end else if (sample_valid_i && !sample_ready_o
                   && (drop_q != 16'hFFFF)) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   assign drop_count_o = drop_q;
`endif

endmodule

// File: tb/tb_beam_coeff_scheduler.sv
// tb_beam_coeff_scheduler: directed bench with a transaction-level model
// of the coefficient scheduler checked every cycle.
module tb_beam_coeff_scheduler;

   logic          clk = 1'b0;
   logic          core_rst;
   logic          sample_valid_i;
   logic          sample_ready_o;
   logic [127:0]  coeff_data_o;
   logic          coeff_valid_o;
   logic          coeff_ready_i;
   logic [2:0]    coeff_beam_o;
   logic          coeff_last_o;
   logic          cfg_wr_en_i;
   logic [2:0]    cfg_wr_addr_i;
   logic [127:0]  cfg_wr_data_i;
   logic [3:0]    cfg_num_beams_i;
   logic          cfg_commit_i;
   logic          cfg_busy_o;
   logic          active_bank_o;
   logic [15:0]   frame_count_o;
`ifdef SAMPLE_DROP_CNT_EN
   logic [15:0]   drop_count_o;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   beam_coeff_scheduler dut (
      .core_clk        (clk),
      .core_rst        (core_rst),
      .sample_valid_i  (sample_valid_i),
      .sample_ready_o  (sample_ready_o),
      .coeff_data_o    (coeff_data_o),
      .coeff_valid_o   (coeff_valid_o),
      .coeff_ready_i   (coeff_ready_i),
      .coeff_beam_o    (coeff_beam_o),
      .coeff_last_o    (coeff_last_o),
      .cfg_wr_en_i     (cfg_wr_en_i),
      .cfg_wr_addr_i   (cfg_wr_addr_i),
      .cfg_wr_data_i   (cfg_wr_data_i),
      .cfg_num_beams_i (cfg_num_beams_i),
      .cfg_commit_i    (cfg_commit_i),
      .cfg_busy_o      (cfg_busy_o),
      .active_bank_o   (active_bank_o),
      .frame_count_o   (frame_count_o)
`ifdef SAMPLE_DROP_CNT_EN
      ,
      .drop_count_o    (drop_count_o)
`endif
   );

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] word(input logic [15:0] x);
      return {8{x}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- transaction-level model ----------------
   typedef struct {
      logic [127:0] d;
      logic [2:0]   b;
      logic         l;
   } ent_t;

   ent_t         q[$];
   logic [127:0] m_bank [2][8];
   logic         m_act;
   int           m_nb_act;
   int           m_nb_shd;
   logic         m_busy;
   int           m_idle;
   logic [15:0]  m_frames;
   logic [15:0]  m_drop;
   logic         m_init = 1'b0;

   // Accepted sets become a queue of expected words; a pending commit
   // swaps banks after two idle cycles with no set in flight.
   always @(posedge clk) begin : model
      bit e, b, rdy, lst;
      int n;
      if (core_rst) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) m_bank[k][i] = '0;
         q.delete();
         m_act = 1'b0; m_nb_act = 1; m_nb_shd = 1;
         m_busy = 1'b0; m_idle = 0; m_frames = '0; m_drop = '0;
         m_init = 1'b1;
      end else if (m_init) begin
         e = (q.size() == 0);
         b = m_busy;
         rdy = e && !b;
         if (sample_valid_i && !rdy && m_drop != 16'hFFFF) m_drop++;
         if (!e && coeff_ready_i) begin
            lst = q[0].l;
            void'(q.pop_front());
            if (lst) m_frames++;
         end
         if (rdy && sample_valid_i)
            for (int i = 0; i < m_nb_act; i++)
               q.push_back('{m_bank[m_act][i], 3'(i), (i == m_nb_act - 1)});
         if (!b && cfg_wr_en_i) m_bank[~m_act][cfg_wr_addr_i] = cfg_wr_data_i;
         if (!b && cfg_commit_i) begin
            n = int'(cfg_num_beams_i);
            m_nb_shd = (n == 0) ? 1 : (n > 8) ? 8 : n;
            m_busy = 1'b1;
            m_idle = 0;
         end
         if (b && e) begin
            m_idle++;
            if (m_idle == 2) begin
               m_act = ~m_act;
               m_nb_act = m_nb_shd;
               m_busy = 1'b0;
               m_idle = 0;
            end
         end
      end
   end

   // Compare every cycle against the model.
   always @(negedge clk) begin
      if (m_init) begin
         chk("ready", 128'(sample_ready_o),
             128'(!core_rst && !m_busy && q.size() == 0));
         chk("valid", 128'(coeff_valid_o), 128'(q.size() != 0));
         chk("busy", 128'(cfg_busy_o), 128'(m_busy));
         chk("bank", 128'(active_bank_o), 128'(m_act));
         chk("frames", 128'(frame_count_o), 128'(m_frames));
         if (q.size() != 0) begin
            chk("data", coeff_data_o, q[0].d);
            chk("beam", 128'(coeff_beam_o), 128'(q[0].b));
            chk("last", 128'(coeff_last_o), 128'(q[0].l));
         end
`ifdef SAMPLE_DROP_CNT_EN
         chk("drop", 128'(drop_count_o), 128'(m_drop));
`endif
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   logic [15:0] exp8 [8];

   // ---------------- directed stimulus ----------------
   initial begin
      core_rst = 1'b1;
      sample_valid_i = 1'b0;
      coeff_ready_i = 1'b1;
      cfg_wr_en_i = 1'b0;
      cfg_wr_addr_i = '0;
      cfg_wr_data_i = '0;
      cfg_num_beams_i = '0;
      cfg_commit_i = 1'b0;
      step();
      step();
      chk("rst_valid", 128'(coeff_valid_o), 128'(0));
      chk("rst_last", 128'(coeff_last_o), 128'(0));
      chk("rst_beam", 128'(coeff_beam_o), 128'(0));
      chk("rst_frames", 128'(frame_count_o), 128'(0));
      chk("rst_ready", 128'(sample_ready_o), 128'(0));
      core_rst = 1'b0;

      // default config: one beam of zeros
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      chk("t1_valid", 128'(coeff_valid_o), 128'(1));
      chk("t1_data", coeff_data_o, 128'(0));
      chk("t1_last", 128'(coeff_last_o), 128'(1));
      step();
      chk("t1_frames", 128'(frame_count_o), 128'(1));

      // load four beams, commit in IDLE
      for (int b = 0; b < 4; b++) begin
         cfg_wr_en_i = 1'b1;
         cfg_wr_addr_i = 3'(b);
         cfg_wr_data_i = word(16'(17 * (b + 1)));
         step();
      end
      cfg_wr_en_i = 1'b0;
      cfg_num_beams_i = 4'd4;
      cfg_commit_i = 1'b1;
      step();
      cfg_commit_i = 1'b0;
      chk("t2_busy", 128'(cfg_busy_o), 128'(1));
      chk("t2_noready", 128'(sample_ready_o), 128'(0));
      step();
      step();
      chk("t2_bank", 128'(active_bank_o), 128'(1));
      chk("t2_idle", 128'(cfg_busy_o), 128'(0));
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      for (int b = 0; b < 4; b++) begin
         chk("t2_data", coeff_data_o, word(16'(17 * (b + 1))));
         chk("t2_beam", 128'(coeff_beam_o), 128'(b));
         chk("t2_last", 128'(coeff_last_o), 128'(b == 3));
         step();
      end
      chk("t2_frames", 128'(frame_count_o), 128'(2));

      // back-pressure during beam 2
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      step();
      step();
      coeff_ready_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("t3_hold_beam", 128'(coeff_beam_o), 128'(2));
         chk("t3_hold_data", coeff_data_o, word(16'h0033));
      end
      coeff_ready_i = 1'b1;
      step();
      chk("t3_beam3", 128'(coeff_beam_o), 128'(3));
      step();
      chk("t3_frames", 128'(frame_count_o), 128'(3));

      // commit while issuing: current set finishes on the old bank
      for (int b = 0; b < 4; b++) begin
         cfg_wr_en_i = 1'b1;
         cfg_wr_addr_i = 3'(b);
         cfg_wr_data_i = word(16'(16'hA0 + b));
         step();
      end
      cfg_wr_en_i = 1'b0;
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      step();
      cfg_num_beams_i = 4'd2;
      cfg_commit_i = 1'b1;
      step();
      cfg_commit_i = 1'b0;
      chk("t4_busy", 128'(cfg_busy_o), 128'(1));
      chk("t4_old", coeff_data_o, word(16'h0033));
      step();
      chk("t4_oldlast", coeff_data_o, word(16'h0044));
      step();
      chk("t4_pend", 128'(sample_ready_o), 128'(0));
      step();
      step();
      chk("t4_bank", 128'(active_bank_o), 128'(0));
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      chk("t4_new0", coeff_data_o, word(16'h00A0));
      step();
      chk("t4_new1", coeff_data_o, word(16'h00A1));
      chk("t4_newlast", 128'(coeff_last_o), 128'(1));
      step();
      chk("t4_frames", 128'(frame_count_o), 128'(5));

      // writes while busy are dropped; num_beams 0 clamps to 1
      cfg_num_beams_i = 4'd0;
      cfg_commit_i = 1'b1;
      step();
      cfg_commit_i = 1'b0;
      cfg_wr_en_i = 1'b1;
      cfg_wr_addr_i = 3'd0;
      cfg_wr_data_i = word(16'hDEAD);
      step();
      step();
      cfg_wr_en_i = 1'b0;
      chk("t5_bank", 128'(active_bank_o), 128'(1));
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      chk("t5_data", coeff_data_o, word(16'h0011));
      chk("t5_last", 128'(coeff_last_o), 128'(1));
      step();
      chk("t5_done", 128'(coeff_valid_o), 128'(0));

      // write with commit in the same cycle; 15 clamps to 8 beams
      cfg_wr_en_i = 1'b1;
      cfg_wr_addr_i = 3'd7;
      cfg_wr_data_i = word(16'h0077);
      cfg_num_beams_i = 4'd15;
      cfg_commit_i = 1'b1;
      step();
      cfg_wr_en_i = 1'b0;
      cfg_commit_i = 1'b0;
      step();
      step();
      chk("t5_bank0", 128'(active_bank_o), 128'(0));
      exp8 = '{16'hA0, 16'hA1, 16'hA2, 16'hA3, 16'h0, 16'h0, 16'h0, 16'h77};
      sample_valid_i = 1'b1;
      step();
      sample_valid_i = 1'b0;
      for (int b = 0; b < 8; b++) begin
         chk("t5_data8", coeff_data_o, word(exp8[b]));
         chk("t5_last8", 128'(coeff_last_o), 128'(b == 7));
         step();
      end
      chk("t5_frames", 128'(frame_count_o), 128'(7));

      // reset in the middle of a set
      sample_valid_i = 1'b1;
      step();
      step();
      step();
      coeff_ready_i = 1'b0;
      step();
      sample_valid_i = 1'b0;
      coeff_ready_i = 1'b1;
      chk("t6_beam2", 128'(coeff_beam_o), 128'(2));
`ifdef SAMPLE_DROP_CNT_EN
      chk("t6_drop", 128'(drop_count_o), 128'(3));
`endif
      core_rst = 1'b1;
      step();
      chk("t6_valid", 128'(coeff_valid_o), 128'(0));
      chk("t6_frames", 128'(frame_count_o), 128'(0));
      chk("t6_bank", 128'(active_bank_o), 128'(0));
      core_rst = 1'b0;
      step();
      chk("t6_ready", 128'(sample_ready_o), 128'(1));
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
